// File: rtl/neonfox_mem_pkg.sv
// Shared types for the NeonFox_PVP memory-port arbitration logic.
package neonfox_mem_pkg;

  // Words per SDRAM burst; the 2-bit offset buses index within one burst.
  localparam int BURST_LEN = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P1   = 2'd1,
    GNT_P2   = 2'd2,
    GNT_P3   = 2'd3
  } grant_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_BURST = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_priority_sel.sv
// Priority encoder for the SDRAM port arbiter: fixed p3 > p2 > p1 order,
// overridden in favour of p1 once it has been starved long enough.
module arb_priority_sel
  import neonfox_mem_pkg::*;
(
  input  logic   p1_req_i,
  input  logic   p2_req_i,
  input  logic   p3_req_i,
  input  logic   force_p1_i,
  output grant_t grant_o
);

  // Starvation override first, then fixed priority.
  always_comb begin
    grant_o = GNT_NONE;
    if (force_p1_i && p1_req_i) begin
      grant_o = GNT_P1;
    end else if (p3_req_i) begin
      grant_o = GNT_P3;
    end else if (p2_req_i) begin
      grant_o = GNT_P2;
    end else if (p1_req_i) begin
      grant_o = GNT_P1;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Three-port burst arbiter in front of the single SDRAM controller port.
// One 4-word burst is granted at a time; address/wren are frozen at grant,
// ready/offset/write data are steered combinationally to the granted port.
module sdram_port_arbiter
  import neonfox_mem_pkg::*;
#(
  parameter logic [31:0] P3_BASE   = 32'h0100_0000,
  parameter int          MAX_WAIT  = 4,
  parameter int          BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        n_reset,

  input  logic        p1_req,
  input  logic [31:0] p1_address,
  output logic        p1_ready,
  output logic [1:0]  p1_offset,

  input  logic        p2_req,
  input  logic        p2_wren,
  input  logic [31:0] p2_address,
  input  logic [15:0] p2_to_mem,
  output logic        p2_ready,
  output logic [1:0]  p2_offset,

  input  logic        p3_req,
  input  logic        p3_wren,
  input  logic [16:0] p3_address,
  input  logic [15:0] p3_to_mem,
  output logic        p3_ready,
  output logic [1:0]  p3_offset,

  output logic        mem_req,
  output logic        mem_wren,
  output logic [31:0] mem_address,
  output logic [15:0] mem_to_mem,
  input  logic        mem_ready,
  input  logic [1:0]  mem_offset
);

  localparam int         WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [1:0] LAST_OFS = 2'(BURST_LEN - 1);

  arb_state_t        state_q, state_d;
  grant_t            grant_q, grant_d;
  grant_t            sel_grant;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              wren_q, wren_d;
  logic              any_req;
  logic              force_p1;

  assign any_req  = p1_req | p2_req | p3_req;
  assign force_p1 = (wait_cnt_q == WAIT_W'(MAX_WAIT));

  arb_priority_sel u_sel (
    .p1_req_i   (p1_req),
    .p2_req_i   (p2_req),
    .p3_req_i   (p3_req),
    .force_p1_i (force_p1),
    .grant_o    (sel_grant)
  );

  // Arbitration FSM next state: grant in IDLE, hold through the burst,
  // one masked DONE cycle so a port's stale request cannot win again.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wren_d     = wren_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d = ARB_ISSUE;
          grant_d = sel_grant;
          case (sel_grant)
            GNT_P1: begin
              addr_d = p1_address;
              wren_d = 1'b0;
            end
            GNT_P2: begin
              addr_d = p2_address;
              wren_d = p2_wren;
            end
            GNT_P3: begin
              addr_d = P3_BASE | {15'b0, p3_address};
              wren_d = p3_wren;
            end
            default: begin
              addr_d = addr_q;
            end
          endcase
        end
        // p1 loses a round only when it asked and someone else won.
        if (!p1_req || (sel_grant == GNT_P1)) begin
          wait_cnt_d = '0;
        end else if (!force_p1) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ARB_ISSUE: begin
        state_d = ARB_BURST;
      end
      ARB_BURST: begin
        if (mem_ready && (mem_offset == LAST_OFS)) begin
          state_d = ARB_DONE;
          grant_d = GNT_NONE;
          wren_d  = 1'b0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q    <= ARB_IDLE;
      grant_q    <= GNT_NONE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wren_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wren_q     <= wren_d;
    end
  end

  assign mem_req     = (state_q == ARB_ISSUE) || (state_q == ARB_BURST);
  assign mem_wren    = wren_q;
  assign mem_address = addr_q;

  // Write data follows the granted port live; p1 is read-only.
  always_comb begin
    case (grant_q)
      GNT_P2:  mem_to_mem = p2_to_mem;
      GNT_P3:  mem_to_mem = p3_to_mem;
      default: mem_to_mem = 16'h0000;
    endcase
  end

  // Strobe and offset steering; grant is NONE outside ISSUE/BURST so
  // strobes seen in IDLE or DONE reach nobody.
  always_comb begin
    p1_ready  = mem_ready & (grant_q == GNT_P1);
    p2_ready  = mem_ready & (grant_q == GNT_P2);
    p3_ready  = mem_ready & (grant_q == GNT_P3);
    p1_offset = (grant_q == GNT_P1) ? mem_offset : 2'd0;
    p2_offset = (grant_q == GNT_P2) ? mem_offset : 2'd0;
    p3_offset = (grant_q == GNT_P3) ? mem_offset : 2'd0;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Three-port burst arbiter between the NeonFox_PVP memory clients and the single SDRAM controller port.
- Port 1: program cache fill. Port 2: data cache fill/writeback. Port 3: video/DMA, 17-bit address.
- Grants one 4-word burst at a time and steers request, address, write data, ready and offset.
- Read data (from_mem) is broadcast by the controller and is not routed here.

Parameters:
P3_BASE, 32'h0100_0000, word-address base OR'ed onto zero-extended p3_address
MAX_WAIT, 4, consecutive p2/p3 grants p1 may lose before it is forced to win
BURST_LEN, 4, words per transaction; must equal 2**width(offset)

Ports:
clk  in  1  system clock
n_reset  in  1  synchronous active-low reset
p1_req  in  1  program-cache burst read request (level)
p1_address  in  32  p1 burst word address
p1_ready  out  1  word valid for p1
p1_offset  out  2  word index within p1 burst
p2_req  in  1  data-cache burst request (level)
p2_wren  in  1  1 = writeback, 0 = fill
p2_address  in  32  p2 burst word address
p2_to_mem  in  16  p2 write data for current offset
p2_ready  out  1  word accepted/valid for p2
p2_offset  out  2  word index within p2 burst
p3_req  in  1  video/DMA request (level)
p3_wren  in  1  p3 write enable
p3_address  in  17  p3 word address
p3_to_mem  in  16  p3 write data
p3_ready  out  1  word accepted/valid for p3
p3_offset  out  2  word index within p3 burst
mem_req  out  1  request to SDRAM controller
mem_wren  out  1  write burst
mem_address  out  32  burst word address
mem_to_mem  out  16  write data to controller
mem_ready  in  1  controller word strobe
mem_offset  in  2  controller word index

Behaviour:
- Reset: state IDLE, grant none, wait_cnt 0. mem_req, mem_wren, all pX_ready 0. mem_address 0; pX_offset 0. Reset mid-burst aborts silently, with no further ready pulses.
- States:
  - IDLE: sample requests. If any request is present, register the grant and go to ISSUE.
  - ISSUE: mem_req=1. Address and wren come from the granted port. Go to BURST.
  - BURST: mem_req held 1. On mem_ready with mem_offset==BURST_LEN-1, go to DONE.
  - DONE: mem_req=0, all requests masked for exactly 1 cycle, then IDLE.
- Priority in IDLE:
  - If wait_cnt==MAX_WAIT and p1_req: p1 wins.
  - Else fixed order p3 > p2 > p1.
- wait_cnt:
  - Increments when p1_req is high and p2 or p3 is granted.
  - Clears when p1 is granted or p1_req is low in IDLE.
  - Saturates at MAX_WAIT.
- mem_address, mem_wren and the grant are registered at IDLE->ISSUE. They stay stable until DONE even if the port changes its inputs.
- p1 is read-only, so mem_wren=0 for a p1 grant.
- mem_address for a p3 grant = P3_BASE | {15'b0, p3_address}.
- mem_to_mem is combinational from the granted port's to_mem; it is 0 when p1 or no port is granted.
- Steering:
  - pX_ready = mem_ready & (grant==X), combinational with zero added latency.
  - pX_offset = mem_offset when granted, else 0.
- Request deassertion:
  - A port drops req no later than the cycle after its offset-3 ready.
  - A request dropped during ISSUE/BURST does not cancel the burst.
  - The DONE gap prevents a second grant to a stale req.
- mem_ready in IDLE or DONE is ignored and raises no pX_ready.
- Simultaneous requests in IDLE resolve by the priority rules above.
- Arbitration latency: req high in IDLE -> mem_req high 1 cycle later (ISSUE).

Decomposition:
- Shared package neonfox_mem_pkg:
  - typedef enum grant_t {GNT_NONE, GNT_P1, GNT_P2, GNT_P3}.
  - typedef enum arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_BURST, ARB_DONE}.
  - localparam BURST_LEN.
- One sub-module, arb_priority_sel: combinational priority encoder taking the three requests and the force_p1 flag, returning grant_t. It keeps the starvation rule unit-testable.

Test Plan:
- Single p1 read: p1_req=1 at address 32'h0000_0040, controller returns 4 strobes -> mem_address=32'h40, mem_wren=0, p1_ready pulses with p1_offset 0,1,2,3, p2/p3_ready stay 0, mem_req low for 1 cycle after offset 3.
- Collision: p1, p2 (wren=1, address 32'h200) and p3 (address 17'h1_0000) all requested in the same IDLE cycle -> p3 granted first with mem_address=32'h0101_0000, then p2 with mem_wren=1 and mem_to_mem tracking p2_to_mem, then p1.
- Starvation: p1_req held while p3 re-requests continuously -> after 4 p3 bursts the 5th grant goes to p1, and wait_cnt returns to 0.
- Address hold: p2 changes p2_address to 32'hFFFF mid-burst -> mem_address stays at the granted value until DONE.
- Stray strobe: mem_ready pulsed in IDLE -> no pX_ready asserted and no state change.
- Reset mid-burst: n_reset=0 at offset 1 -> next cycle mem_req=0, all ready 0, state IDLE. After release, a pending p2_req is granted normally.
